// File: rtl/uart_pkg.sv
// Shared UART receive types and line-level constants.
// Parity support in the receiver is enabled with the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Expected parity bit: even when odd=0, odd when odd=1.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to the idle-high level.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: start/mid-bit sampling, LSB-first shift, stop check.
// Optional parity bit checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 data_rx,
  input  logic                 parity_bit,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 active_flag,
  output logic                 done_flag,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned         CNT_W     = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]          IDX_LAST  = 3'(DATA_BITS - 1);

  rx_state_e            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_out_n;
  logic                 valid_n, done_n, ferr_n, active_n;
  logic                 rx_s;
  logic                 par_bad_c;

  uart_sync2 u_sync (
    .clk   (baud_clk),
    .reset (reset),
    .d     (data_rx),
    .q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_rx, par_rx_n, perr_n;

  assign par_bad_c = (par_rx != calc_parity(shift, parity_bit));
`else
  logic unused_parity_bit;

  assign unused_parity_bit = parity_bit;
  assign par_bad_c         = 1'b0;
  assign parity_err        = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_out    <= '0;
      valid       <= 1'b0;
      done_flag   <= 1'b0;
      frame_err   <= 1'b0;
      active_flag <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_rx      <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      data_out    <= data_out_n;
      valid       <= valid_n;
      done_flag   <= done_n;
      frame_err   <= ferr_n;
      active_flag <= active_n;
`ifdef UART_RX_PARITY_EN
      par_rx      <= par_rx_n;
      parity_err  <= perr_n;
`endif
    end
  end

  // Next-state, counters and output pulses.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    data_out_n = data_out;
    valid_n    = 1'b0;
    done_n     = 1'b0;
    ferr_n     = 1'b0;
    active_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_rx_n   = par_rx;
    perr_n     = 1'b0;
`endif

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_s == START_BIT) state_n = START;
      end

      // Re-check the line at mid start bit to reject glitches.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = (rx_s == START_BIT) ? DATA : IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n    = '0;
          par_rx_n = rx_s;
          state_n  = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n  = '0;
          done_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_n = par_bad_c;
`endif
          if (rx_s == STOP_BIT) begin
            state_n = IDLE;
            if (!par_bad_c) begin
              valid_n    = 1'b1;
              data_out_n = shift;
            end
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // Held-low line must return idle before a new start can be seen.
      BREAK: begin
        cnt_n = '0;
        if (rx_s == LINE_IDLE) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    active_n = (state_n == DATA) || (state_n == PARITY) || (state_n == STOP);
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: table of single frames plus glitch,
// back-to-back and mid-frame reset sequences.
module tb_uart_rx_sipo;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_ACTIVE = 10 * OS;
`else
  localparam int FRAME_ACTIVE = 9 * OS;
`endif

  logic       baud_clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_rx = 1'b1;
  logic       parity_bit = 1'b0;
  logic [7:0] data_out;
  logic       valid, active_flag, done_flag, frame_err, parity_err;

  uart_rx_sipo #(.OVERSAMPLE(OS)) dut (
    .baud_clk    (baud_clk),
    .reset       (reset),
    .data_rx     (data_rx),
    .parity_bit  (parity_bit),
    .data_out    (data_out),
    .valid       (valid),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 baud_clk = ~baud_clk;

  int checks = 0;
  int errors = 0;

  // Event counters, sampled on the falling edge.
  int         n_valid = 0, n_done = 0, n_ferr = 0, n_perr = 0, n_active = 0, n_coin = 0;
  logic [7:0] vq[$];

  always @(negedge baud_clk) begin
    if (valid) begin
      n_valid++;
      vq.push_back(data_out);
    end
    if (done_flag) n_done++;
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (active_flag) n_active++;
    if (done_flag && (valid || frame_err || parity_err)) n_coin++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    data_rx = v;
    repeat (OS) @(negedge baud_clk);
  endtask

  task automatic idle(input int cycles);
    data_rx = 1'b1;
    repeat (cycles) @(negedge baud_clk);
  endtask

  // Start, 8 data LSB first, optional parity, then stop (or stop_low bits held low).
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic pflip,
                            input int stop_low);
    parity_bit = pbit;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pbit ^ pflip);
`else
    if (pflip) send_bit(1'b1);
`endif
    if (stop_low == 0) send_bit(1'b1);
    else repeat (stop_low) send_bit(1'b0);
    data_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       pflip;
    int         stop_low;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int b_valid, b_done, b_ferr, b_perr, b_active, b_coin, b_q;

    vecs.push_back(vec_t'{8'h4A, 1'b0, 1'b0, 0, 1, 0, 0, 8'h4A});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 0, 1, 0, 0, 8'h00});
    vecs.push_back(vec_t'{8'hFF, 1'b0, 1'b0, 0, 1, 0, 0, 8'hFF});
    vecs.push_back(vec_t'{8'h81, 1'b0, 1'b0, 0, 1, 0, 0, 8'h81});
    vecs.push_back(vec_t'{8'h5A, 1'b0, 1'b0, 3, 0, 1, 0, 8'h81});
`ifdef UART_RX_PARITY_EN
    vecs.push_back(vec_t'{8'h5A, 1'b0, 1'b0, 0, 1, 0, 0, 8'h5A});
    vecs.push_back(vec_t'{8'h4A, 1'b0, 1'b1, 0, 0, 0, 1, 8'h5A});
    vecs.push_back(vec_t'{8'h4A, 1'b1, 1'b0, 0, 1, 0, 0, 8'h4A});
`endif

    // Reset state.
    repeat (3) @(negedge baud_clk);
    reset = 1'b0;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_active", int'(active_flag), 0);
    chk("rst_done", int'(done_flag), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_parity_err", int'(parity_err), 0);
    idle(20);

    // Single frames from the table.
    foreach (vecs[k]) begin
      b_valid = n_valid; b_done = n_done; b_ferr = n_ferr;
      b_perr = n_perr; b_active = n_active; b_coin = n_coin;
      send_frame(vecs[k].data, vecs[k].pbit, vecs[k].pflip, vecs[k].stop_low);
      idle(2 * OS);
      chk($sformatf("v%0d_valid", k), n_valid - b_valid, vecs[k].exp_valid);
      chk($sformatf("v%0d_done", k), n_done - b_done, 1);
      chk($sformatf("v%0d_frame_err", k), n_ferr - b_ferr, vecs[k].exp_ferr);
      chk($sformatf("v%0d_parity_err", k), n_perr - b_perr, vecs[k].exp_perr);
      chk($sformatf("v%0d_active_cycles", k), n_active - b_active, FRAME_ACTIVE);
      chk($sformatf("v%0d_pulse_with_done", k), n_coin - b_coin, 1);
      chk($sformatf("v%0d_data_out", k), int'(data_out), int'(vecs[k].exp_data));
    end

    // Short glitch on the idle line must be rejected.
    b_valid = n_valid; b_done = n_done; b_active = n_active;
    data_rx = 1'b0;
    repeat (4) @(negedge baud_clk);
    idle(3 * OS);
    chk("glitch_active", n_active - b_active, 0);
    chk("glitch_done", n_done - b_done, 0);
    chk("glitch_valid", n_valid - b_valid, 0);

    // Three back-to-back frames, one stop bit, no idle gap.
    b_valid = n_valid; b_done = n_done; b_q = vq.size();
    send_frame(8'h4A, 1'b0, 1'b0, 0);
    send_frame(8'h4A, 1'b0, 1'b0, 0);
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    idle(2 * OS);
    chk("b2b_valid", n_valid - b_valid, 3);
    chk("b2b_done", n_done - b_done, 3);
    if (vq.size() >= b_q + 3) begin
      chk("b2b_byte0", int'(vq[b_q]), 8'h4A);
      chk("b2b_byte1", int'(vq[b_q + 1]), 8'h4A);
      chk("b2b_byte2", int'(vq[b_q + 2]), 8'h5A);
    end else begin
      chk("b2b_bytes_captured", vq.size() - b_q, 3);
    end

    // Reset at mid bit 4 of 0x4A; the upstream transmitter shares the reset and idles.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h4A >> i));
    data_rx = 1'b0;
    repeat (OS / 2) @(negedge baud_clk);
    chk("pre_reset_active", int'(active_flag), 1);
    reset = 1'b1;
    @(negedge baud_clk);
    reset = 1'b0;
    data_rx = 1'b1;
    chk("mid_rst_data_out", int'(data_out), 0);
    chk("mid_rst_active", int'(active_flag), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_done", int'(done_flag), 0);
    b_valid = n_valid; b_done = n_done; b_active = n_active;
    idle(12 * OS);
    chk("after_rst_valid", n_valid - b_valid, 0);
    chk("after_rst_done", n_done - b_done, 0);
    chk("after_rst_active", n_active - b_active, 0);

    // Clean frame after the aborted one.
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    idle(2 * OS);
    chk("post_rst_valid", n_valid - b_valid, 1);
    chk("post_rst_data_out", int'(data_out), 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
